// File: rtl/sum_accumulator.sv
// Accumulates BLOCK_LEN decoded adder/subtractor results into a saturating signed sum,
// then holds the block result until the downstream side takes it.
module sum_accumulator #(
  parameter int BLOCK_LEN = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  sum,
  input  logic                        carry,
  input  logic                        sub_mode,
  input  logic                        clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic [7:0]                  count,
  output logic                        sat
);

  // state | meaning
  // IDLE  | empty block, waiting for the first sample
  // ACCUM | block partially filled, still accepting
  // HOLD  | block complete, result presented until handoff
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           count_q, count_d;
  logic                 sat_q, sat_d;

  logic [9:0]           sample;
  logic [ACC_WIDTH:0]   sample_ext;
  logic [ACC_WIDTH:0]   base_ext;
  logic [ACC_WIDTH:0]   total;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] acc_next;

  // In sub mode carry=1 means no borrow, so the sign bits are the inverted carry.
  assign sample     = sub_mode ? {~carry, ~carry, sum} : {1'b0, carry, sum};
  assign sample_ext = {{(ACC_WIDTH-9){sample[9]}}, sample};
  assign base_ext   = {acc_q[ACC_WIDTH-1], acc_q};
  assign total      = base_ext + sample_ext;
  assign ovf        = total[ACC_WIDTH] != total[ACC_WIDTH-1];
  assign acc_next   = ovf ? (total[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : total[ACC_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          // acc_q, count_q and sat_q are all zero in IDLE, so one path serves both states.
          if (in_valid) begin
            acc_d   = acc_next;
            count_d = count_q + 8'd1;
            sat_d   = sat_q | ovf;
            state_d = (count_d == LAST_CNT) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign acc       = acc_q;
  assign count     = count_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed scenarios plus a randomized run against a
// saturating-arithmetic reference model, on 16-bit and 10-bit accumulator instances.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, sub_mode, carry, clear, out_ready;
  logic [7:0]  sum;
  logic        in_ready16, out_valid16, sat16;
  logic [15:0] acc16;
  logic [7:0]  count16;
  logic        in_ready10, out_valid10, sat10;
  logic [9:0]  acc10;
  logic [7:0]  count10;

  int n_checks = 0;
  int n_fail   = 0;

  bit     m_hold;
  int     m_cnt;
  longint m_acc16, m_acc10;
  bit     m_sat16, m_sat10;

  always #5 clk = ~clk;

  sum_accumulator #(.BLOCK_LEN(4), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .sum(sum), .carry(carry), .sub_mode(sub_mode), .clear(clear),
    .out_valid(out_valid16), .out_ready(out_ready), .acc(acc16),
    .count(count16), .sat(sat16)
  );

  sum_accumulator #(.BLOCK_LEN(4), .ACC_WIDTH(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready10),
    .sum(sum), .carry(carry), .sub_mode(sub_mode), .clear(clear),
    .out_valid(out_valid10), .out_ready(out_ready), .acc(acc10),
    .count(count10), .sat(sat10)
  );

  function automatic longint decode(input logic [7:0] s, input logic c, input logic sm);
    if (!sm) return longint'(c) * 256 + longint'(s);
    return longint'(s) - (c ? 0 : 256);
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int w,
                                     inout bit s);
    longint r, mx, mn;
    r  = a + b;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    if (r > mx) begin r = mx; s = 1'b1; end
    if (r < mn) begin r = mn; s = 1'b1; end
    return r;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_cnt = 0; m_acc16 = 0; m_acc10 = 0; m_sat16 = 0; m_sat10 = 0;
  endtask

  task automatic model_step();
    longint v;
    if (clear) model_reset();
    else if (m_hold) begin
      if (out_ready) model_reset();
    end else if (in_valid) begin
      v = decode(sum, carry, sub_mode);
      m_acc16 = sat_add(m_acc16, v, 16, m_sat16);
      m_acc10 = sat_add(m_acc10, v, 10, m_sat10);
      m_cnt++;
      if (m_cnt == 4) m_hold = 1;
    end
  endtask

  // Inputs are set between a negedge and the next posedge; outputs are read at the negedge.
  task automatic tick();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; sum = 8'd0; carry = 0; sub_mode = 0; clear = 0; out_ready = 0;
  endtask

  task automatic accept(input logic [7:0] s, input logic c, input logic sm);
    in_valid = 1; sum = s; carry = c; sub_mode = sm;
    tick();
    in_valid = 0;
  endtask

  task automatic handoff();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    n_checks++; if (in_ready16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready16); end
    n_checks++; if (out_valid16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid16); end
    n_checks++; if (acc16 !== 16'd0) begin n_fail++; $display("FAIL reset_acc: got %0h expected 0", acc16); end
    n_checks++; if (count16 !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count16); end
    n_checks++; if (sat16 !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat16); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_add();
    for (int i = 0; i < 3; i++) accept(8'd200, 1'b1, 1'b0);
    n_checks++; if (out_valid16 !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b expected 0", out_valid16); end
    n_checks++; if (count16 !== 8'd3) begin n_fail++; $display("FAIL add_count3: got %0d expected 3", count16); end
    accept(8'd200, 1'b1, 1'b0);
    n_checks++; if (out_valid16 !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", out_valid16); end
    n_checks++; if (in_ready16 !== 1'b0) begin n_fail++; $display("FAIL add_in_ready: got %b expected 0", in_ready16); end
    n_checks++; if (acc16 !== 16'h0720) begin n_fail++; $display("FAIL add_acc: got %0h expected 720", acc16); end
    n_checks++; if (count16 !== 8'd4) begin n_fail++; $display("FAIL add_count: got %0d expected 4", count16); end
    n_checks++; if (sat16 !== 1'b0) begin n_fail++; $display("FAIL add_sat: got %b expected 0", sat16); end
    handoff();
    n_checks++; if (out_valid16 !== 1'b0 || acc16 !== 16'd0 || count16 !== 8'd0) begin
      n_fail++; $display("FAIL add_handoff: got valid=%b acc=%0h cnt=%0d expected 0/0/0", out_valid16, acc16, count16);
    end
  endtask

  task automatic test_sub();
    for (int i = 0; i < 4; i++) accept(8'hFB, 1'b0, 1'b1);
    n_checks++; if (acc16 !== 16'hFFEC) begin n_fail++; $display("FAIL sub_acc: got %0h expected ffec", acc16); end
    n_checks++; if (sat16 !== 1'b0) begin n_fail++; $display("FAIL sub_sat: got %b expected 0", sat16); end
    n_checks++; if (out_valid16 !== 1'b1) begin n_fail++; $display("FAIL sub_valid: got %b expected 1", out_valid16); end
    handoff();
  endtask

  task automatic test_saturation();
    accept(8'hFF, 1'b1, 1'b0);
    n_checks++; if (acc10 !== 10'd511 || sat10 !== 1'b0) begin
      n_fail++; $display("FAIL sat_first: got acc=%0d sat=%b expected 511/0", acc10, sat10);
    end
    for (int i = 0; i < 3; i++) accept(8'hFF, 1'b1, 1'b0);
    n_checks++; if (acc10 !== 10'd511) begin n_fail++; $display("FAIL sat_acc10: got %0d expected 511", acc10); end
    n_checks++; if (sat10 !== 1'b1) begin n_fail++; $display("FAIL sat_flag10: got %b expected 1", sat10); end
    n_checks++; if (acc16 !== 16'd2044 || sat16 !== 1'b0) begin
      n_fail++; $display("FAIL sat_wide: got acc=%0d sat=%b expected 2044/0", acc16, sat16);
    end
    handoff();
    n_checks++; if (sat10 !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %b expected 0", sat10); end
  endtask

  task automatic test_backpressure();
    longint held;
    logic [7:0] s;
    for (int i = 0; i < 4; i++) begin
      s = 8'($urandom);
      accept(s, 1'($urandom), 1'($urandom));
    end
    held = m_acc16;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; sum = 8'($urandom); carry = 1'($urandom); out_ready = 0;
      tick();
      n_checks++; if (in_ready16 !== 1'b0 || out_valid16 !== 1'b1) begin
        n_fail++; $display("FAIL bp_flags: got rdy=%b vld=%b expected 0/1", in_ready16, out_valid16);
      end
      n_checks++; if (acc16 !== 16'(held) || count16 !== 8'd4) begin
        n_fail++; $display("FAIL bp_stable: got acc=%0h cnt=%0d expected %0h/4", acc16, count16, 16'(held));
      end
    end
    out_ready = 1; in_valid = 1;
    tick();
    out_ready = 0;
    n_checks++; if (count16 !== 8'd0 || in_ready16 !== 1'b1) begin
      n_fail++; $display("FAIL bp_handoff: got cnt=%0d rdy=%b expected 0/1", count16, in_ready16);
    end
    accept(8'd37, 1'b0, 1'b0);
    n_checks++; if (count16 !== 8'd1 || acc16 !== 16'd37) begin
      n_fail++; $display("FAIL bp_next: got cnt=%0d acc=%0d expected 1/37", count16, acc16);
    end
    clear = 1; tick(); clear = 0;
  endtask

  task automatic test_reset_mid_block();
    accept(8'd10, 1'b0, 1'b0);
    accept(8'd20, 1'b0, 1'b0);
    #2 rst_n = 0;
    #1;
    n_checks++; if (acc16 !== 16'd0 || count16 !== 8'd0 || out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      n_fail++; $display("FAIL rst_async: got acc=%0d cnt=%0d vld=%b rdy=%b expected 0/0/0/1", acc16, count16, out_valid16, in_ready16);
    end
    @(negedge clk);
    in_valid = 1; sum = 8'd99;
    tick();
    n_checks++; if (count16 !== 8'd0) begin n_fail++; $display("FAIL rst_no_accept: got %0d expected 0", count16); end
    in_valid = 0;
    rst_n = 1;
    for (int i = 0; i < 4; i++) accept(8'd50, 1'b0, 1'b0);
    n_checks++; if (acc16 !== 16'd200 || out_valid16 !== 1'b1) begin
      n_fail++; $display("FAIL rst_fresh: got acc=%0d vld=%b expected 200/1", acc16, out_valid16);
    end
    handoff();
  endtask

  task automatic test_clear();
    accept(8'd100, 1'b0, 1'b0);
    accept(8'd100, 1'b0, 1'b0);
    in_valid = 1; sum = 8'd100; clear = 1;
    tick();
    in_valid = 0; clear = 0;
    n_checks++; if (count16 !== 8'd0 || acc16 !== 16'd0 || in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
      n_fail++; $display("FAIL clear_state: got cnt=%0d acc=%0d rdy=%b vld=%b expected 0/0/1/0", count16, acc16, in_ready16, out_valid16);
    end
    for (int i = 0; i < 4; i++) accept(8'd3, 1'b0, 1'b0);
    n_checks++; if (acc16 !== 16'd12) begin n_fail++; $display("FAIL clear_fresh: got %0d expected 12", acc16); end
    handoff();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 1) == 1);
      clear     = ($urandom_range(0, 39) == 0);
      sum       = 8'($urandom);
      carry     = 1'($urandom);
      sub_mode  = 1'($urandom);
      tick();
      n_checks++; if (in_ready16 !== !m_hold || out_valid16 !== m_hold) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got rdy=%b vld=%b expected %b/%b", i, in_ready16, out_valid16, !m_hold, m_hold);
      end
      n_checks++; if (count16 !== 8'(m_cnt)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count16, m_cnt); end
      n_checks++; if (acc16 !== 16'(m_acc16) || sat16 !== m_sat16) begin
        n_fail++; $display("FAIL rand_acc16[%0d]: got %0h/%b expected %0h/%b", i, acc16, sat16, 16'(m_acc16), m_sat16);
      end
      n_checks++; if (acc10 !== 10'(m_acc10) || sat10 !== m_sat10) begin
        n_fail++; $display("FAIL rand_acc10[%0d]: got %0h/%b expected %0h/%b", i, acc10, sat10, 10'(m_acc10), m_sat10);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_saturation();
    test_backpressure();
    test_reset_mid_block();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
